branch_predict_unit: RTL and testbench

- Parametrised successor to the execute-stage branch resolution logic of the pipelined RV32I core.
- Adds a PC-indexed branch history table (BHT) of saturating counters, queried in Fetch and trained in Execute.
- Adds unsigned branches (BLTU/BGEU), misprediction recovery and performance counters.
- Sits between the hazard unit and the PC mux. Fetch-side target computation stays in the datapath.

---
 rtl/branch_predict_unit.sv | 125 ++++++++++++
 tb/tb_branch_predict_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch direction predictor and resolver. A PC-indexed table of saturating counters
// is read in Fetch and trained in Execute; redirect select and perf counters come from Execute.

module bht_cell #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             up,
    output logic [CNT_W-1:0] cnt
);
    // Weakly-not-taken start point; for a 1-bit counter this is 0.
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'((2 ** (CNT_W - 1)) - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (we) begin
            if (up && cnt != '1)
                cnt <= cnt + 1'b1;
            else if (!up && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   PCF,
    output logic              PredTakenF,
    input  logic [XLEN-1:0]   PCE,
    input  logic              PredTakenE,
    input  logic              ValidE,
    input  logic              StallE,
    input  logic [2:0]        BranchE,
    input  logic [1:0]        JumpE,
    input  logic              ZeroE,
    input  logic              ResSignE,
    input  logic              BorrowE,
    output logic [1:0]        PCSrcE,
    output logic              FlushE,
    output logic [STAT_W-1:0] BranchCnt,
    output logic [STAT_W-1:0] MispredCnt
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [BHT_ENTRIES-1:0][CNT_W-1:0] bht;
    logic [IDX_W-1:0] idx_f, idx_e;
    logic             active, is_br, taken, train;

    assign idx_f = PCF[IDX_W+1:2];
    assign idx_e = PCE[IDX_W+1:2];

    // Byte offset and aliasing bits are intentionally not part of the index.
    logic unused_pc;
    assign unused_pc = ^{PCF[XLEN-1:IDX_W+2], PCF[1:0], PCE[XLEN-1:IDX_W+2], PCE[1:0]};

    // Read sees only the registered table, so a same-edge update is not bypassed.
    assign PredTakenF = bht[idx_f][CNT_W-1];

    assign active = ValidE & ~StallE;
    assign is_br  = (BranchE != 3'b000) && (BranchE != 3'b111);
    assign train  = active & is_br;

    always_comb begin
        taken = 1'b0;
        case (BranchE)
            3'b001:  taken = ZeroE;
            3'b010:  taken = ~ZeroE;
            3'b011:  taken = ResSignE;
            3'b100:  taken = ~ResSignE;
            3'b101:  taken = BorrowE;
            3'b110:  taken = ~BorrowE;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        PCSrcE = 2'b00;
        if (active) begin
            if (is_br) begin
                if (taken && !PredTakenE)
                    PCSrcE = 2'b01;
                else if (!taken && PredTakenE)
                    PCSrcE = 2'b11;
            end else if (JumpE == 2'b11) begin
                PCSrcE = 2'b01;
            end else if (JumpE == 2'b10) begin
                PCSrcE = 2'b10;
            end
        end
    end

    assign FlushE = (PCSrcE != 2'b00);

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        bht_cell #(.CNT_W(CNT_W)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (train && (idx_e == IDX_W'(i))),
            .up    (taken),
            .cnt   (bht[i])
        );
    end

    // Perf counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else if (train) begin
            if (BranchCnt != '1)
                BranchCnt <= BranchCnt + 1'b1;
            if ((taken != PredTakenE) && (MispredCnt != '1))
                MispredCnt <= MispredCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: hand-computed redirects, counter training,
// saturation, aliasing and asynchronous reset.

module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, PCE;
    logic        PredTakenF, PredTakenE, ValidE, StallE;
    logic [2:0]  BranchE;
    logic [1:0]  JumpE;
    logic        ZeroE, ResSignE, BorrowE;
    logic [1:0]  PCSrcE;
    logic        FlushE;
    logic [15:0] BranchCnt, MispredCnt;

    int total = 0;
    int bad   = 0;

    branch_predict_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCF        (PCF),
        .PredTakenF (PredTakenF),
        .PCE        (PCE),
        .PredTakenE (PredTakenE),
        .ValidE     (ValidE),
        .StallE     (StallE),
        .BranchE    (BranchE),
        .JumpE      (JumpE),
        .ZeroE      (ZeroE),
        .ResSignE   (ResSignE),
        .BorrowE    (BorrowE),
        .PCSrcE     (PCSrcE),
        .FlushE     (FlushE),
        .BranchCnt  (BranchCnt),
        .MispredCnt (MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Apply an Execute-stage op and let combinational outputs settle.
    task automatic drive(input logic [2:0] br, input logic [1:0] jmp, input logic z,
                         input logic rs, input logic bw, input logic pe, input logic [31:0] pce);
        BranchE = br; JumpE = jmp; ZeroE = z; ResSignE = rs; BorrowE = bw;
        PredTakenE = pe; PCE = pce; ValidE = 1'b1; StallE = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [1:0] src);
        chk({tag, ".src"}, 32'(PCSrcE), 32'(src));
        chk({tag, ".flush"}, 32'(FlushE), 32'(src != 2'b00));
    endtask

    task automatic chk_state(input string tag, input logic pf, input int bc, input int mc);
        chk({tag, ".pf"}, 32'(PredTakenF), 32'(pf));
        chk({tag, ".bc"}, 32'(BranchCnt), 32'(bc));
        chk({tag, ".mc"}, 32'(MispredCnt), 32'(mc));
    endtask

    initial begin
        rst_n = 1'b0; PCF = 32'h100; PCE = 32'h0; PredTakenE = 1'b0; ValidE = 1'b0;
        StallE = 1'b0; BranchE = 3'b000; JumpE = 2'b00; ZeroE = 1'b0; ResSignE = 1'b0; BorrowE = 1'b0;
        #12;
        chk_state("reset", 1'b0, 0, 0);
        chk_res("reset", 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // entry 0: 01 -> 10, mispredicted taken
        drive(3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        chk_res("beq1", 2'b01);
        chk("beq1.preupd", 32'(PredTakenF), 32'd0);
        tick();
        chk_state("beq1", 1'b1, 1, 1);

        drive(3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        chk_res("beq2", 2'b00);
        tick();
        chk_state("beq2", 1'b1, 2, 1);
        drive(3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        chk_state("beq3", 1'b1, 3, 1);

        // saturated 11 -> 10 -> 01; a wrapped counter would still predict taken
        drive(3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        chk_res("bne1", 2'b11);
        tick();
        chk_state("bne1", 1'b1, 4, 2);
        drive(3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        chk_state("bne2", 1'b0, 5, 3);

        drive(3'b101, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        chk_res("bltu", 2'b01);
        tick();
        chk_state("bltu", 1'b1, 6, 4);

        drive(3'b110, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        chk_res("bgeu", 2'b00);
        tick();
        chk_state("bgeu", 1'b0, 7, 4);

        drive(3'b011, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
        chk_res("blt", 2'b00);
        tick();
        chk_state("blt", 1'b1, 8, 4);

        drive(3'b100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
        chk_res("bge", 2'b11);
        tick();
        chk_state("bge", 1'b0, 9, 5);

        // jumps: no training, no stats
        drive(3'b000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        chk_res("jal", 2'b01);
        tick();
        chk_state("jal", 1'b0, 9, 5);
        drive(3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
        chk_res("jalr", 2'b10);
        drive(3'b111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
        chk_res("none", 2'b00);

        drive(3'b000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
        StallE = 1'b1; #1;
        chk_res("jal.stall", 2'b00);
        StallE = 1'b0; ValidE = 1'b0; #1;
        chk_res("jal.bubble", 2'b00);

        // branch wins over jump; not taken and predicted not taken: 01 -> 00
        drive(3'b001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
        chk_res("brjmp", 2'b00);
        tick();
        chk_state("brjmp", 1'b0, 10, 5);

        // stalled branch must not train or count
        drive(3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        StallE = 1'b1; #1;
        chk_res("stall", 2'b00);
        tick();
        chk_state("stall", 1'b0, 10, 5);

        // alias: 0x200 trains the entry read by 0x100 (00 -> 01 -> 10)
        drive(3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
        tick();
        chk_state("alias1", 1'b0, 11, 6);
        drive(3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
        chk("alias2.preupd", 32'(PredTakenF), 32'd0);
        tick();
        chk_state("alias2", 1'b1, 12, 7);
        PCF = 32'h104; #1;
        chk("other.idx", 32'(PredTakenF), 32'd0);
        PCF = 32'h100; #1;

        // async reset mid-cycle, held across an edge with a qualifying branch
        ValidE = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        chk_state("areset", 1'b0, 0, 0);
        drive(3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        tick();
        chk_state("rst.hold", 1'b0, 0, 0);
        ValidE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; #1;
        chk("rst.after", 32'(PredTakenF), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
